// File: rtl/p_box_stream.sv
// Buffered MacGuffin 48-bit P-box (forward / inverse) over CHANNELS lanes with a DEPTH-entry FIFO.
// Optional feature macro: P_BOX_STREAM_STATS_EN adds the saturating stat_count accepted-word counter.
module p_box_stream #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inverse,
  input  logic [48*CHANNELS-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [48*CHANNELS-1:0]   out_data,
  output logic                     out_inverse
`ifdef P_BOX_STREAM_STATS_EN
  ,
  output logic [31:0]              stat_count
`endif
);

  localparam int W  = 48 * CHANNELS;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Source bit for output bits 47 down to 0 (index 0 is output bit 47).
  localparam int SRC [48] = '{
    45, 42, 25, 22,  4,  2,
    46, 43, 24, 21,  7,  1,
    44, 41, 23, 18, 15,  0,
    35, 33, 30, 29, 11,  5,
    47, 37, 28, 17,  9,  3,
    40, 39, 19, 16, 14, 10,
    38, 32, 26, 20, 13,  8,
    36, 34, 31, 27, 12,  6
  };

  logic [W-1:0]  fwd_data;
  logic [W-1:0]  inv_data;
  logic [W-1:0]  perm_data;

  genvar gi, gk;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      for (gk = 0; gk < 48; gk++) begin : g_bit
        assign fwd_data[48*gi + 47 - gk]  = in_data[48*gi + SRC[gk]];
        assign inv_data[48*gi + SRC[gk]]  = in_data[48*gi + 47 - gk];
      end
    end
  endgenerate

  assign perm_data = in_inverse ? inv_data : fwd_data;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push;
  logic          pop;

  // Mode bit travels in the top bit of each stored entry.
  logic [W:0]    mem [DEPTH];
  logic [W:0]    head;

  assign in_ready  = (count_reg != FULL_COUNT) && !rst;
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is never reset; empty-state outputs are masked below instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_inverse, perm_data};
    end
  end

  assign head        = mem[rd_ptr_reg];
  assign out_data    = out_valid ? head[W-1:0] : '0;
  assign out_inverse = out_valid & head[W];

`ifdef P_BOX_STREAM_STATS_EN
  logic [31:0] stat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reg <= '0;
    end else if (push && (stat_reg != 32'hFFFF_FFFF)) begin
      stat_reg <= stat_reg + 32'd1;
    end
  end

  assign stat_count = stat_reg;
`endif

endmodule

// File: tb/tb_p_box_stream.sv
// Scoreboard bench for p_box_stream: randomized words against a table-driven P / P-inverse model.
module tb_p_box_stream;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int W     = 48 * CH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_inverse = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  wire          in_ready;
  wire          out_valid;
  wire          out_inverse;
  wire [W-1:0]  out_data;
`ifdef P_BOX_STREAM_STATS_EN
  wire [31:0]   stat_count;
`endif

  p_box_stream #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inverse (in_inverse),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inverse(out_inverse)
`ifdef P_BOX_STREAM_STATS_EN
    ,
    .stat_count (stat_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit ready_cmd = 1'b0;
  logic [W-1:0] exp_q[$];
  logic         exp_inv_q[$];
  logic [W-1:0] capt_q[$];
  int           pop_cyc[$];

  // Permutation table as written: output bits 47..0 by source bit.
  int src [48] = '{45,42,25,22,4,2, 46,43,24,21,7,1, 44,41,23,18,15,0, 35,33,30,29,11,5,
                   47,37,28,17,9,3, 40,39,19,16,14,10, 38,32,26,20,13,8, 36,34,31,27,12,6};

  function automatic logic [47:0] pbox(input logic [47:0] d, input logic inv);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 48; k++) begin
      if (!inv) r[47-k] = d[src[k]];
      else      r[src[k]] = d[47-k];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[48*i +: 48] = pbox(d[48*i +: 48], inv);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Monitor: pops the scoreboard whenever the DUT hands over a word.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic ei;
    if (out_valid && out_ready) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      capt_q.push_back(out_data);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got data=%h inv=%b, nothing expected", out_data, out_inverse);
      end else begin
        e  = exp_q.pop_front();
        ei = exp_inv_q.pop_front();
        if (out_data !== e || out_inverse !== ei) begin
          errors++;
          $display("FAIL pop_data: got %h inv=%b, expected %h inv=%b", out_data, out_inverse, e, ei);
        end else begin
          $display("pop  data=%h inv=%b", out_data, out_inverse);
        end
      end
    end else if (!out_valid) begin
      checks++;
      if (out_data !== '0 || out_inverse !== 1'b0) begin
        errors++;
        $display("FAIL empty_zero: got data=%h inv=%b, expected zeros", out_data, out_inverse);
      end
    end
  end

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic inv, input logic [W-1:0] e);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_inverse = inv;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        exp_inv_q.push_back(inv);
        done = 1'b1;
        $display("push data=%h inv=%b", d, inv);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance, expected in_ready within 400 cycles");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk_int("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] v;
    logic [W-1:0] orig[$];
    logic [W-1:0] fwd_out[$];
    int base;

    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_in_ready", in_ready, 1'b0);
`ifdef P_BOX_STREAM_STATS_EN
    chk_int("rst_stat", int'(stat_count), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk_bit("ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed single-bit vectors, plus one-cycle latency from empty.
    ready_cmd = 1'b0;
    send({48'h0000_0000_0040, 48'h2000_0000_0000}, 1'b0, {48'h0000_0000_0001, 48'h8000_0000_0000});
    chk_bit("latency_valid", out_valid, 1'b1);
    ready_cmd = 1'b1;
    drain();
    send({48'h0, 48'h8000_0000_0000}, 1'b1, {48'h0, 48'h2000_0000_0000});
    drain();

    // Walk every single bit and its complement in both modes.
    rand_ready = 1'b1;
    for (int b = 0; b < 48; b++) begin
      v = '0;
      v[47:0] = 48'h1 << b;
      d = {~v[47:0], v[47:0]};
      send(d, 1'b0, model(d, 1'b0));
      send(d, 1'b1, model(d, 1'b1));
    end
    drain();

    // Round trip: forward outputs re-fed in inverse mode must restore the originals.
    capt_q.delete();
    for (int i = 0; i < 200; i++) begin
      d = {$urandom, $urandom, $urandom};
      orig.push_back(d);
      send(d, 1'b0, model(d, 1'b0));
    end
    drain();
    chk_int("capture_count", capt_q.size(), 200);
    fwd_out = capt_q;
    for (int i = 0; i < fwd_out.size(); i++) send(fwd_out[i], 1'b1, orig[i]);
    drain();
    rand_ready = 1'b0;

    // Full FIFO with backpressure, then release.
    ready_cmd = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, 1'(i & 1), model(d, 1'(i & 1)));
    end
    chk_bit("full_in_ready", in_ready, 1'b0);
    d = {$urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_data = d;
    in_inverse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_bit("full_hold", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    base = n_pops;
    pop_cyc.delete();
    ready_cmd = 1'b1;
    send(d, 1'b0, model(d, 1'b0));
    drain();
    chk_int("full_pop_count", n_pops - base, 5);
    if (pop_cyc.size() >= 5) chk_int("full_back_to_back", pop_cyc[4] - pop_cyc[0], 4);
    else chk_int("full_pop_cycles", pop_cyc.size(), 5);

    // Concurrent push/pop at count 2.
    ready_cmd = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, 1'b0, model(d, 1'b0));
    end
    ready_cmd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, 1'b1, model(d, 1'b1));
    end
    base = n_pops;
    repeat (4) @(negedge clk);
    chk_int("steady_residue", n_pops - base, 2);
    chk_int("steady_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset with 3 entries queued.
    ready_cmd = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, 1'b0, model(d, 1'b0));
    end
    rst = 1'b1;
    #1;
    chk_bit("midrst_out_valid", out_valid, 1'b0);
    chk_bit("midrst_in_ready", in_ready, 1'b0);
`ifdef P_BOX_STREAM_STATS_EN
    chk_int("midrst_stat", int'(stat_count), 0);
`endif
    exp_q.delete();
    exp_inv_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_cmd = 1'b1;
    d = {$urandom, $urandom, $urandom};
    send(d, 1'b1, model(d, 1'b1));
    drain();

`ifdef P_BOX_STREAM_STATS_EN
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, 1'b0, model(d, 1'b0));
    end
    drain();
    chk_int("stat_five", int'(stat_count), 5);
    force dut.stat_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stat_reg;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, 1'b0, model(d, 1'b0));
    end
    drain();
    chk_int("stat_saturate", int'(stat_count), int'(32'hFFFF_FFFF));
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
